// File: rtl/pipe_credit_buffer_pkg.sv
// Shared defaults and width helpers for the credit-managed landing buffer.
// Every file that sizes pointers or counters from DEPTH imports this package.
package pipe_credit_buffer_pkg;

    localparam int DEFAULT_NUM_BITS = 16;

    // Pointer width for a DEPTH-entry ring; at least one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy/credit width: must also be able to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/pipe_credit_buffer.sv
// Landing buffer at the tail of a non-stallable delay line. Upstream may only
// launch a word while it holds a credit; a credit returns on every pop.
module pipe_credit_buffer
    import pipe_credit_buffer_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         issue,
    output logic                         issue_ok,
    input  logic                         in_valid,
    input  logic [NUM_BITS-1:0]          in_data,
    output logic                         out_valid,
    output logic [NUM_BITS-1:0]          out_data,
    input  logic                         out_ready,
    output logic [cnt_width(DEPTH)-1:0]  count,
    output logic                         overflow,
    output logic                         credit_err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [NUM_BITS-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          overflow_q, overflow_d;
    logic          credit_err_q, credit_err_d;

    logic push;
    logic pop;
    logic take;

    always_comb begin
        out_valid = (count_q != '0);
        issue_ok  = (credits_q != '0);
        pop       = out_valid & out_ready;
        // A full buffer can still accept when the head leaves in the same cycle.
        push      = in_valid & ((count_q < DEPTH_C) | pop);
        take      = issue & issue_ok;

        wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Saturate at DEPTH so words forced in without a credit cannot mint extras.
        credits_d = credits_q;
        if (take && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !take && (credits_q != DEPTH_C)) begin
            credits_d = credits_q + CW'(1);
        end

        overflow_d   = overflow_q   | (in_valid & ~push);
        credit_err_d = credit_err_q | (issue & ~issue_ok);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            credits_q    <= DEPTH_C;
            overflow_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            credits_q    <= credits_d;
            overflow_q   <= overflow_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Storage carries no reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign out_data   = mem[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// Chains a credit-obeying issuer through an L-stage delay line into the buffer
// and checks directed corner cases plus a randomized in-order stream.
module tb_pipe_credit_buffer;

    localparam int NB = 16;
    localparam int DP = 4;
    localparam int MAXL = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          issue;
    logic          issue_ok;
    logic          in_valid;
    logic [NB-1:0] in_data;
    logic          out_valid;
    logic [NB-1:0] out_data;
    logic          out_ready;
    logic [2:0]    count;
    logic          overflow;
    logic          credit_err;

    logic [NB-1:0] issue_data;
    logic          force_en;
    logic          force_v;
    logic [NB-1:0] force_d;
    int            lat;

    logic [MAXL-1:0] dl_v;
    logic [NB-1:0]   dl_d [MAXL];

    int n_checks = 0;
    int n_errors = 0;
    logic [NB-1:0] sb [$];

    pipe_credit_buffer #(.NUM_BITS(NB), .DEPTH(DP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    // Upstream delay line: only words launched with a credit enter it.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dl_v <= '0;
        end else begin
            dl_v    <= {dl_v[MAXL-2:0], issue & issue_ok};
            dl_d[0] <= issue_data;
            for (int i = 1; i < MAXL; i++) dl_d[i] <= dl_d[i-1];
        end
    end

    assign in_valid = force_en ? force_v : dl_v[lat-1];
    assign in_data  = force_en ? force_d : dl_d[lat-1];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues four consecutive words then lets the delay line drain into the buffer.
    task automatic fill(input logic [NB-1:0] base);
        for (int i = 0; i < 4; i++) begin
            issue      = 1'b1;
            issue_data = base + NB'(i);
            step();
        end
        issue = 1'b0;
        check_eq("fill_issue_ok_low", {31'd0, issue_ok}, 32'd0);
        repeat (lat) step();
        check_eq("fill_count", {29'd0, count}, 32'd4);
    endtask

    task automatic expect_pop(input string tag, input logic [NB-1:0] exp);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
        $display("pop %s data=%h", tag, out_data);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic hard_reset();
        #2 rstn = 1'b0;
        #1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; issue = 1'b0; out_ready = 1'b0; issue_data = '0;
        force_en = 1'b0; force_v = 1'b0; force_d = '0; lat = 3;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", {29'd0, count}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_issue_ok", {31'd0, issue_ok}, 32'd1);
        check_eq("rst_credits", {29'd0, dut.credits_q}, 32'd4);
        check_eq("rst_flags", {30'd0, overflow, credit_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Fill with consumer stalled, then drain in order.
        fill(16'h0001);
        check_eq("fd_overflow", {31'd0, overflow}, 32'd0);
        check_eq("fd_credits", {29'd0, dut.credits_q}, 32'd0);
        check_eq("fd_stable", {16'd0, out_data}, 32'h0001);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("fd_drain_data", {16'd0, out_data}, 32'(i));
            $display("pop fd data=%h", out_data);
            step();
        end
        out_ready = 1'b0;
        check_eq("fd_empty", {29'd0, count}, 32'd0);
        check_eq("fd_credits_back", {29'd0, dut.credits_q}, 32'd4);

        // Full buffer with simultaneous push and pop.
        fill(16'h0011);
        force_en = 1'b1; force_v = 1'b1; force_d = 16'h00AA; out_ready = 1'b1;
        step();
        force_en = 1'b0; out_ready = 1'b0;
        check_eq("pp_count", {29'd0, count}, 32'd4);
        check_eq("pp_overflow", {31'd0, overflow}, 32'd0);
        expect_pop("pp0", 16'h0012);
        expect_pop("pp1", 16'h0013);
        expect_pop("pp2", 16'h0014);
        expect_pop("pp3", 16'h00AA);
        check_eq("pp_credits_sat", {29'd0, dut.credits_q}, 32'd4);

        // Overflow: word arriving into a full, stalled buffer is dropped.
        fill(16'h0021);
        force_en = 1'b1; force_v = 1'b1; force_d = 16'h0BAD;
        step();
        force_en = 1'b0;
        check_eq("ov_flag", {31'd0, overflow}, 32'd1);
        check_eq("ov_count", {29'd0, count}, 32'd4);
        step();
        check_eq("ov_sticky", {31'd0, overflow}, 32'd1);
        expect_pop("ov0", 16'h0021);
        expect_pop("ov1", 16'h0022);
        expect_pop("ov2", 16'h0023);
        expect_pop("ov3", 16'h0024);
        check_eq("ov_empty", {31'd0, out_valid}, 32'd0);

        // Credit abuse, then pop coinciding with a legal issue.
        fill(16'h0031);
        issue = 1'b1; issue_data = 16'h0BAD;
        step();
        issue = 1'b0;
        check_eq("ce_flag", {31'd0, credit_err}, 32'd1);
        check_eq("ce_credits", {29'd0, dut.credits_q}, 32'd0);
        expect_pop("ce0", 16'h0031);
        check_eq("ce_credit_ret", {29'd0, dut.credits_q}, 32'd1);
        issue = 1'b1; issue_data = 16'h0035; out_ready = 1'b1;
        step();
        issue = 1'b0; out_ready = 1'b0;
        check_eq("ce_take_pop", {29'd0, dut.credits_q}, 32'd1);
        repeat (lat) step();
        check_eq("ce_count", {29'd0, count}, 32'd3);
        check_eq("ce_sticky", {31'd0, credit_err}, 32'd1);

        // Reset mid-stream with three entries stored.
        #2 rstn = 1'b0;
        #1;
        check_eq("mr_count", {29'd0, count}, 32'd0);
        check_eq("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mr_issue_ok", {31'd0, issue_ok}, 32'd1);
        check_eq("mr_credits", {29'd0, dut.credits_q}, 32'd4);
        check_eq("mr_flags", {30'd0, overflow, credit_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        issue = 1'b1; issue_data = 16'h0041;
        step();
        issue = 1'b0;
        check_eq("first_issue", {29'd0, dut.credits_q}, 32'd3);
        repeat (lat - 1) step();
        check_eq("no_bypass", {31'd0, out_valid}, 32'd0);
        step();
        expect_pop("first", 16'h0041);

        // Random stream over delay-line lengths 1..5.
        for (int l = 1; l <= MAXL; l++) begin
            int inflight;
            hard_reset();
            lat = l;
            sb.delete();
            step();
            for (int c = 0; c < 2000; c++) begin
                inflight = 0;
                for (int i = 0; i < l; i++) inflight += int'(dl_v[i]);
                check_eq("rnd_invariant", 32'(int'(dut.credits_q) + int'(count) + inflight), 32'd4);
                issue      = issue_ok & ($urandom_range(0, 9) < 6);
                issue_data = 16'($urandom);
                out_ready  = ($urandom_range(0, 1) == 1);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check_eq("rnd_unexpected", 32'd1, 32'd0);
                    else check_eq("rnd_order", {16'd0, out_data}, {16'd0, sb.pop_front()});
                end
                if (issue) sb.push_back(issue_data);
                step();
            end
            issue = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < l + DP + 4; c++) begin
                if (out_valid) begin
                    if (sb.size() == 0) check_eq("rnd_unexpected", 32'd1, 32'd0);
                    else check_eq("rnd_drain", {16'd0, out_data}, {16'd0, sb.pop_front()});
                end
                step();
            end
            out_ready = 1'b0;
            check_eq("rnd_no_loss", 32'(sb.size()), 32'd0);
            check_eq("rnd_overflow", {31'd0, overflow}, 32'd0);
            check_eq("rnd_credit_err", {31'd0, credit_err}, 32'd0);
            $display("random L=%0d done", l);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_credit_buffer.md
PIPE_CREDIT_BUFFER -- requirements
Module: pipe_credit_buffer

Interface
REQ-001 Parameter NUM_BITS, default 16, data word width.
REQ-002 Parameter DEPTH, default 4, storage entries and initial credits; power of two, 2..64.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 issue  input  1  upstream launched one word into the non-stallable delay line this cycle.
REQ-006 issue_ok  output  1  a credit is available; upstream may issue this cycle.
REQ-007 in_valid  input  1  delay-line output word valid this cycle; no ready path exists.
REQ-008 in_data  input  NUM_BITS  delay-line output word.
REQ-009 out_valid  output  1  head entry available to consumer.
REQ-010 out_data  output  NUM_BITS  head entry contents.
REQ-011 out_ready  input  1  consumer accepts head; pop = out_valid & out_ready.
REQ-012 count  output  clog2(DEPTH)+1  current stored entries.
REQ-013 overflow  output  1  sticky: a word arrived with no room.
REQ-014 credit_err  output  1  sticky: issue asserted while issue_ok low.

Function
REQ-015 Storage SHALL be a DEPTH-entry circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits each, wrapping modulo DEPTH.
REQ-016 Push = in_valid & (count < DEPTH | pop); a pushed word SHALL be written at wr_ptr and wr_ptr advanced.
REQ-017 in_valid with count == DEPTH and no pop SHALL drop the word, leave pointers/count unchanged, and set overflow.
REQ-018 Pop SHALL advance rd_ptr; count SHALL update by +push -pop, so simultaneous push and pop leaves count unchanged, including at full and at empty.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL equal the entry at rd_ptr; a word pushed at edge N is visible on out_data from edge N onward (one-cycle in-to-out latency), no combinational in_data-to-out_data path.
REQ-020 Push to empty buffer SHALL NOT bypass; out_valid rises the cycle after in_valid.
REQ-021 Credit counter, width clog2(DEPTH)+1, SHALL change by -take +pop, where take = issue & issue_ok.
REQ-022 issue_ok SHALL equal (credits != 0), decoded from registers only.
REQ-023 issue with issue_ok low SHALL NOT change credits and SHALL set credit_err.
REQ-024 Credits SHALL never exceed DEPTH nor go below 0; invariant credits + count + in-flight words == DEPTH holds when upstream obeys issue_ok.
REQ-025 overflow and credit_err SHALL stay set until reset.
REQ-026 out_data SHALL hold stable while out_valid high and out_ready low.

Reset
REQ-027 On rstn low, asynchronously: wr_ptr=0, rd_ptr=0, count=0, credits=DEPTH, overflow=0, credit_err=0; hence out_valid=0, issue_ok=1.
REQ-028 Storage array SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-029 Reset mid-operation SHALL discard stored and in-flight accounting; upstream must flush its delay line under the same reset.
REQ-030 First push/issue SHALL be honoured on the first rising edge after rstn deasserts.

Structure
REQ-031 Shared package/header SHALL hold default NUM_BITS and a clog2 width helper; no block-local typedefs.
REQ-032 No sub-module SHALL be instantiated; storage is an inferred register/LUT-RAM array.
REQ-033 System bench SHALL chain issuer -> pipeline (NUM_STAGES=L) -> pipe_credit_buffer.

Verification
REQ-034 Reset: DEPTH=4, rstn pulsed low mid-stream with 3 stored -> count=0, out_valid=0, issue_ok=1, credits=4 immediately.
REQ-035 Fill/drain: issue 4 words 0x0001..0x0004 through L=3 delay line, out_ready=0 -> issue_ok low after 4th issue, count=4, no overflow; then out_ready=1 -> outputs 0x0001..0x0004 in order on 4 consecutive cycles.
REQ-036 Full with simultaneous push/pop: count=4, in_valid=1 data 0x00AA, out_ready=1 -> count stays 4, overflow=0, 0x00AA emerges last.
REQ-037 Overflow: force in_valid with count=4, out_ready=0, data 0x0BAD -> word dropped, overflow=1 sticky, contents unchanged.
REQ-038 Credit abuse: credits=0, issue=1 -> credits stay 0, credit_err=1; pop same cycle as legal issue -> credits unchanged.
REQ-039 Random: 10k cycles random issue (obeying issue_ok) and out_ready, L=1..5 -> in-order, no loss, overflow=0, invariant REQ-024 holds each cycle.
